overlay_mixer: RTL and testbench

Output compositor that sits directly downstream of the emblem overlay generator and in front of the VGA pins. Each pixel clock it combines the background colour with the emblem's `draw`/`rgb` pair, using a frame-synchronous fade-in/fade-out state machine. It registers colour and sync through a fixed two-cycle pipeline so the RGB and sync outputs stay aligned.

---
 rtl/overlay_mixer.sv | 189 ++++++++++++++++++
 tb/tb_overlay_mixer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/overlay_mixer.sv
// overlay_mixer: blends the emblem overlay onto the background with a frame-synchronous fade in/out.
// Latency: rgb, hsync and vsync all lag their inputs by exactly 2 clk cycles (two register stages).
// Backpressure: none; a free-running pixel stream that accepts one pixel per clock, always.
//
// Ports:
//   clk, rst             pixel clock; synchronous active-high reset
//   hsync_in, vsync_in   syncs from the timing generator (inactive level = SYNC_IDLE)
//   active               visible-area flag, aligned with bg_rgb / emblem_*
//   bg_rgb               background colour, RRGGBB
//   emblem_draw          overlay pixel valid
//   emblem_rgb           overlay colour, RRGGBB
//   enable               request to show the overlay (sampled on frame ticks only)
//   hsync, vsync, rgb    pipelined syncs and final colour
//   alpha                overlay weight 0..4 (updated once per frame)
//   busy                 high while fading in or out
module overlay_mixer #(
    parameter int   FADE_STEP_FRAMES = 4,
    parameter logic SYNC_IDLE        = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       active,
    input  logic [5:0] bg_rgb,
    input  logic       emblem_draw,
    input  logic [5:0] emblem_rgb,
    input  logic       enable,
    output logic       hsync,
    output logic       vsync,
    output logic [5:0] rgb,
    output logic [2:0] alpha,
    output logic       busy
);

    localparam int CNT_W = $clog2(FADE_STEP_FRAMES) + 1;
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(FADE_STEP_FRAMES - 1);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_FADE_IN  = 2'd1;
    localparam logic [1:0] S_SHOWN    = 2'd2;
    localparam logic [1:0] S_FADE_OUT = 2'd3;

    // Stage 1 registers
    logic       hs1_q, vs1_q, act1_q, draw1_q;
    logic [5:0] bg1_q, emb1_q;

    // Stage 2 registers
    logic       hs2_q, vs2_q;
    logic [5:0] rgb_q, rgb_d;

    // Fade control
    logic [1:0]       state_q, state_d;
    logic [2:0]       alpha_q, alpha_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             frame_tick;

    // vs2_q is the stage-1 vsync delayed by one cycle, so it doubles as the
    // edge-detector history bit; both reset to SYNC_IDLE so reset never
    // produces a tick.
    assign frame_tick = (vs2_q == SYNC_IDLE) && (vs1_q != SYNC_IDLE);

    // Per-channel weighted mix: (e*a + b*(4-a)) >> 2. The sum is at most 12,
    // so 4 bits hold it without overflow; the shift truncates.
    function automatic logic [1:0] blend_ch(input logic [1:0] e, input logic [1:0] b,
                                            input logic [2:0] a);
        logic [3:0] e4, b4, a4, ia4, sum;
        e4  = {2'b00, e};
        b4  = {2'b00, b};
        a4  = {1'b0, a};
        ia4 = 4'd4 - a4;
        sum = (e4 * a4) + (b4 * ia4);
        return sum[3:2];
    endfunction

    always_comb begin
        rgb_d = 6'd0;
        if (!act1_q) begin
            rgb_d = 6'd0;
        end else if (!draw1_q) begin
            rgb_d = bg1_q;
        end else begin
            rgb_d[5:4] = blend_ch(emb1_q[5:4], bg1_q[5:4], alpha_q);
            rgb_d[3:2] = blend_ch(emb1_q[3:2], bg1_q[3:2], alpha_q);
            rgb_d[1:0] = blend_ch(emb1_q[1:0], bg1_q[1:0], alpha_q);
        end
    end

    // Fade FSM. Entering a fade from a steady state takes the first alpha
    // step immediately; a reversal only flips direction and restarts the
    // step counter.
    always_comb begin
        state_d = state_q;
        alpha_d = alpha_q;
        cnt_d   = cnt_q;
        if (frame_tick) begin
            case (state_q)
                S_IDLE: begin
                    if (enable) begin
                        state_d = S_FADE_IN;
                        alpha_d = 3'd1;
                        cnt_d   = '0;
                    end
                end
                S_FADE_IN: begin
                    if (!enable) begin
                        state_d = S_FADE_OUT;
                        cnt_d   = '0;
                    end else if (cnt_q == STEP_LAST) begin
                        cnt_d = '0;
                        if (alpha_q < 3'd4) begin
                            alpha_d = alpha_q + 3'd1;
                        end
                        if (alpha_q >= 3'd3) begin
                            state_d = S_SHOWN;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_SHOWN: begin
                    if (!enable) begin
                        state_d = S_FADE_OUT;
                        alpha_d = 3'd3;
                        cnt_d   = '0;
                    end
                end
                S_FADE_OUT: begin
                    if (enable) begin
                        state_d = S_FADE_IN;
                        cnt_d   = '0;
                    end else if (cnt_q == STEP_LAST) begin
                        cnt_d = '0;
                        if (alpha_q > 3'd0) begin
                            alpha_d = alpha_q - 3'd1;
                        end
                        if (alpha_q <= 3'd1) begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    alpha_d = 3'd0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hs1_q   <= SYNC_IDLE;
            vs1_q   <= SYNC_IDLE;
            act1_q  <= 1'b0;
            draw1_q <= 1'b0;
            bg1_q   <= 6'd0;
            emb1_q  <= 6'd0;
            hs2_q   <= SYNC_IDLE;
            vs2_q   <= SYNC_IDLE;
            rgb_q   <= 6'd0;
            state_q <= S_IDLE;
            alpha_q <= 3'd0;
            cnt_q   <= '0;
        end else begin
            hs1_q   <= hsync_in;
            vs1_q   <= vsync_in;
            act1_q  <= active;
            draw1_q <= emblem_draw;
            bg1_q   <= bg_rgb;
            emb1_q  <= emblem_rgb;
            hs2_q   <= hs1_q;
            vs2_q   <= vs1_q;
            rgb_q   <= rgb_d;
            state_q <= state_d;
            alpha_q <= alpha_d;
            cnt_q   <= cnt_d;
        end
    end

    assign hsync = hs2_q;
    assign vsync = vs2_q;
    assign rgb   = rgb_q;
    assign alpha = alpha_q;
    assign busy  = (state_q == S_FADE_IN) || (state_q == S_FADE_OUT);

endmodule

// File: tb/tb_overlay_mixer.sv
// tb_overlay_mixer: directed stimulus with a scoreboard of expected outputs keyed by cycle.
// Latency: expectations are queued with the cycle they are due; a negedge monitor pops them.
// Backpressure: none; the DUT takes one pixel per clock.
module tb_overlay_mixer;

    logic       clk = 1'b0;
    logic       rst;
    logic       hsync_in, vsync_in, active, emblem_draw, enable;
    logic [5:0] bg_rgb, emblem_rgb;
    logic       hsync, vsync, busy;
    logic [5:0] rgb;
    logic [2:0] alpha;

    always #5 clk = ~clk;

    overlay_mixer #(
        .FADE_STEP_FRAMES(2),
        .SYNC_IDLE       (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .active     (active),
        .bg_rgb     (bg_rgb),
        .emblem_draw(emblem_draw),
        .emblem_rgb (emblem_rgb),
        .enable     (enable),
        .hsync      (hsync),
        .vsync      (vsync),
        .rgb        (rgb),
        .alpha      (alpha),
        .busy       (busy)
    );

    localparam int K_RGB   = 0;
    localparam int K_HS    = 1;
    localparam int K_VS    = 2;
    localparam int K_ALPHA = 3;
    localparam int K_BUSY  = 4;

    typedef struct {
        int    due;
        int    kind;
        int    val;
        string nm;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Queue an expectation for the output visible 'lag' cycles from now.
    task automatic push_exp(input int lag, input int kind, input int val, input string nm);
        exp_t e;
        e.due  = cyc + lag;
        e.kind = kind;
        e.val  = val;
        e.nm   = nm;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every expectation due in the current cycle.
    always @(negedge clk) begin : monitor
        int got;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                case (sb[i].kind)
                    K_RGB:   got = int'(rgb);
                    K_HS:    got = int'(hsync);
                    K_VS:    got = int'(vsync);
                    K_ALPHA: got = int'(alpha);
                    default: got = int'(busy);
                endcase
                n_chk++;
                if (got == sb[i].val) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s at cycle %0d: got %0b, expected %0b",
                             sb[i].nm, cyc, got, sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    // One short frame: 2 cycles of vsync pulse (blanked), then 4 visible pixels.
    // exp_rgb is the hand-computed blend for the alpha this frame should carry.
    task automatic frame(input logic en, input int exp_a, input int exp_b,
                         input logic [5:0] bg, input logic ed, input logic [5:0] er,
                         input logic [5:0] exp_rgb, input string nm);
        for (int i = 0; i < 6; i++) begin
            hsync_in    = 1'b1;
            vsync_in    = (i < 2) ? 1'b0 : 1'b1;
            active      = (i >= 2);
            bg_rgb      = bg;
            emblem_draw = ed;
            emblem_rgb  = er;
            enable      = en;
            push_exp(2, K_RGB, (i >= 2) ? int'(exp_rgb) : 0, {nm, "_rgb"});
            push_exp(2, K_VS, (i < 2) ? 0 : 1, {nm, "_vsync"});
            if (i == 0) begin
                push_exp(2, K_ALPHA, exp_a, {nm, "_alpha"});
                push_exp(2, K_BUSY, exp_b, {nm, "_busy"});
            end
            if (i == 3) begin
                push_exp(2, K_ALPHA, exp_a, {nm, "_alpha_midframe"});
            end
            step();
        end
    endtask

    initial begin
        rst         = 1'b1;
        hsync_in    = 1'b1;
        vsync_in    = 1'b1;
        active      = 1'b0;
        bg_rgb      = 6'd0;
        emblem_draw = 1'b0;
        emblem_rgb  = 6'd0;
        enable      = 1'b0;

        // Reset state
        step();
        step();
        push_exp(0, K_RGB, 0, "rst_rgb");
        push_exp(0, K_HS, 1, "rst_hsync");
        push_exp(0, K_VS, 1, "rst_vsync");
        push_exp(0, K_ALPHA, 0, "rst_alpha");
        push_exp(0, K_BUSY, 0, "rst_busy");
        rst = 1'b0;
        step();

        // Latency: hsync falls and colour appears exactly two cycles later
        active = 1'b1;
        bg_rgb = 6'b101010;
        push_exp(2, K_RGB, 6'b101010, "lat_rgb_pre");
        step();
        hsync_in = 1'b0;
        push_exp(1, K_HS, 1, "lat_hsync_not_early");
        push_exp(2, K_HS, 0, "lat_hsync");
        push_exp(2, K_RGB, 6'b101010, "lat_rgb");
        step();
        hsync_in = 1'b1;
        active   = 1'b0;
        push_exp(1, K_RGB, 6'b101010, "lat_rgb_hold");
        push_exp(2, K_RGB, 0, "lat_blank");
        push_exp(2, K_HS, 1, "lat_hsync_rise");
        step();
        step();
        step();

        // Fade in with 2 frames per step: alpha 1,1,2,2,3,3,4
        frame(1'b1, 1, 1, 6'b000000, 1'b1, 6'b110110, 6'b000000, "fin1");
        frame(1'b1, 1, 1, 6'b000000, 1'b1, 6'b110110, 6'b000000, "fin2");
        frame(1'b1, 2, 1, 6'b000000, 1'b1, 6'b110110, 6'b010001, "fin3");
        frame(1'b1, 2, 1, 6'b000000, 1'b1, 6'b110110, 6'b010001, "fin4");
        frame(1'b1, 3, 1, 6'b000000, 1'b1, 6'b110110, 6'b100001, "fin5");
        frame(1'b1, 3, 1, 6'b000000, 1'b1, 6'b110110, 6'b100001, "fin6");
        frame(1'b1, 4, 0, 6'b000000, 1'b1, 6'b110110, 6'b110110, "fin7");

        // Saturation: alpha holds at 4; draw=0 passes the background through
        for (int f = 0; f < 20; f++) begin
            if (f % 2 == 0)
                frame(1'b1, 4, 0, 6'b011011, 1'b0, 6'b110110, 6'b011011, "sat_bg");
            else
                frame(1'b1, 4, 0, 6'b011011, 1'b1, 6'b110110, 6'b110110, "sat_emb");
        end

        // Fade out from SHOWN starts at alpha 3; mixed bg/emblem weights
        frame(1'b0, 3, 1, 6'b011011, 1'b1, 6'b110110, 6'b100110, "fout1");

        // Mid-frame reset with alpha 3, hsync active and pixels visible
        hsync_in    = 1'b0;
        active      = 1'b1;
        emblem_draw = 1'b1;
        step();
        step();
        rst = 1'b1;
        step();
        push_exp(0, K_RGB, 0, "midrst_rgb");
        push_exp(0, K_HS, 1, "midrst_hsync");
        push_exp(0, K_VS, 1, "midrst_vsync");
        push_exp(0, K_ALPHA, 0, "midrst_alpha");
        push_exp(0, K_BUSY, 0, "midrst_busy");
        rst      = 1'b0;
        hsync_in = 1'b1;
        active   = 1'b0;
        enable   = 1'b1;
        for (int i = 0; i < 4; i++) step();
        push_exp(0, K_ALPHA, 0, "postrst_no_tick_alpha");
        push_exp(0, K_BUSY, 0, "postrst_no_tick_busy");
        step();

        // Reversal during fade-in at alpha 2, then fade out to IDLE
        frame(1'b1, 1, 1, 6'b000000, 1'b1, 6'b110110, 6'b000000, "rev_in1");
        frame(1'b1, 1, 1, 6'b000000, 1'b1, 6'b110110, 6'b000000, "rev_in2");
        frame(1'b1, 2, 1, 6'b000000, 1'b1, 6'b110110, 6'b010001, "rev_in3");
        frame(1'b0, 2, 1, 6'b000000, 1'b1, 6'b110110, 6'b010001, "rev_flip");
        frame(1'b0, 2, 1, 6'b000000, 1'b1, 6'b110110, 6'b010001, "rev_out1");
        frame(1'b0, 1, 1, 6'b000000, 1'b1, 6'b110110, 6'b000000, "rev_out2");
        frame(1'b0, 1, 1, 6'b000000, 1'b1, 6'b110110, 6'b000000, "rev_out3");
        frame(1'b0, 0, 0, 6'b010101, 1'b1, 6'b110110, 6'b010101, "rev_idle1");
        frame(1'b0, 0, 0, 6'b010101, 1'b1, 6'b110110, 6'b010101, "rev_idle2");

        for (int i = 0; i < 4; i++) step();

        if (sb.size() != 0) begin
            n_chk++;
            $display("FAIL scoreboard_drain: %0d expectations never checked, expected 0",
                     sb.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
